// File: rtl/audio_echo.sv
// -----------------------------------------------------------------------------
// audio_echo
//   Stereo echo/delay stage placed between the I2S receive and transmit paths.
//   Each falling edge of the ADC word select (after synchronisation) frames one
//   L/R sample pair. The pair is mixed with a delayed, attenuated copy read from
//   a circular RAM delay line, the feedback mix is written back into the line,
//   and the result is presented to the transmitter.
//
// Ports
//   mclk          in   master clock
//   reset_n       in   asynchronous active-low reset
//   ws_in         in   ADC word select, asynchronous to mclk
//   l_data_rx     in   received left sample  (signed, d_width)
//   r_data_rx     in   received right sample (signed, d_width)
//   effect_en     in   1 = echo on, 0 = bypass (sampled once per frame, in MIX)
//   l_data_tx     out  left sample to transmitter
//   r_data_tx     out  right sample to transmitter
//   sample_valid  out  one-cycle pulse while freshly updated tx samples are shown
//   overrun       out  sticky flag: a frame tick arrived while a frame was busy
// -----------------------------------------------------------------------------
module audio_echo #(
    parameter int d_width       = 24,
    parameter int delay_samples = 4096,
    parameter int addr_width    = 12,
    parameter int mix_shift     = 1,
    parameter int fb_shift      = 2
) (
    input  logic               mclk,
    input  logic               reset_n,
    input  logic               ws_in,
    input  logic [d_width-1:0] l_data_rx,
    input  logic [d_width-1:0] r_data_rx,
    input  logic               effect_en,
    output logic [d_width-1:0] l_data_tx,
    output logic [d_width-1:0] r_data_tx,
    output logic               sample_valid,
    output logic               overrun
);

    localparam int ext_width = d_width + 2;
    localparam int ram_depth = 2 * (2 ** addr_width);

    localparam logic [addr_width-1:0] last_ptr = addr_width'(delay_samples - 1);

    localparam logic signed [ext_width-1:0] sat_max = {3'b000, {(d_width-1){1'b1}}};
    localparam logic signed [ext_width-1:0] sat_min = {3'b111, {(d_width-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        RD_L,
        RD_R,
        MIX,
        WR_L,
        WR_R,
        DONE
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Word-select synchroniser and falling-edge detector
    // ------------------------------------------------------------------
    logic ws_meta, ws_sync, ws_prev;
    logic tick;

    // Resetting to 0 means a ws_in that is already low after reset cannot
    // produce a spurious tick; only a genuine 1->0 transition does.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            ws_meta <= 1'b0;
            ws_sync <= 1'b0;
            ws_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its neighbour, which is what builds the shift chain.
            ws_meta <= ws_in;
            ws_sync <= ws_meta;
            ws_prev <= ws_sync;
        end
    end

    assign tick = ws_prev & ~ws_sync;

    // ------------------------------------------------------------------
    // Saturating add of a sample and a pre-shifted delay-line value
    // ------------------------------------------------------------------
    function automatic logic [d_width-1:0] add_sat(
        input logic [d_width-1:0] x,
        input logic [d_width-1:0] d_shifted
    );
        logic signed [ext_width-1:0] sum;
        sum = $signed({{2{x[d_width-1]}}, x}) +
              $signed({{2{d_shifted[d_width-1]}}, d_shifted});
        if (sum > sat_max) begin
            return sat_max[d_width-1:0];
        end else if (sum < sat_min) begin
            return sat_min[d_width-1:0];
        end else begin
            return sum[d_width-1:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // Delay-line RAM: single port, synchronous read, interleaved L/R
    // ------------------------------------------------------------------
    logic [d_width-1:0]    mem [ram_depth];
    logic [d_width-1:0]    ram_q;
    logic [addr_width-1:0] ptr;
    logic                  ram_sel;
    logic                  ram_re;
    logic                  ram_we;
    logic [d_width-1:0]    ram_wdata;
    logic [addr_width:0]   ram_addr;

    assign ram_addr = {ptr, ram_sel};

    // NOTE: the memory array has no reset; stale contents are masked by the
    // primed flag until a full delay period has been written.
    always_ff @(posedge mclk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end else if (ram_re) begin
            ram_q <= mem[ram_addr];
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    logic [d_width-1:0] x_l, x_r;
    logic [d_width-1:0] d_l;
    logic [d_width-1:0] y_l, y_r;
    logic [d_width-1:0] w_l, w_r;
    logic               primed;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        ram_sel    = 1'b0;
        ram_re     = 1'b0;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        unique case (state)
            IDLE: begin
                if (tick) begin
                    state_next = RD_L;
                end
            end
            RD_L: begin
                ram_re     = 1'b1;
                state_next = RD_R;
            end
            RD_R: begin
                ram_sel    = 1'b1;
                ram_re     = 1'b1;
                state_next = MIX;
            end
            MIX: begin
                state_next = WR_L;
            end
            WR_L: begin
                ram_we     = 1'b1;
                ram_wdata  = w_l;
                state_next = WR_R;
            end
            WR_R: begin
                ram_sel    = 1'b1;
                ram_we     = 1'b1;
                ram_wdata  = w_r;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // The right-channel delayed sample comes straight off the RAM output in
    // MIX; the left one was captured a cycle earlier in RD_R. Both are forced
    // to zero until the line has been filled once.
    logic [d_width-1:0] d_r;
    logic [d_width-1:0] d_l_wet, d_r_wet, d_l_fb, d_r_fb;

    assign d_r     = primed ? ram_q : '0;
    assign d_l_wet = d_width'($signed(d_l) >>> mix_shift);
    assign d_r_wet = d_width'($signed(d_r) >>> mix_shift);
    assign d_l_fb  = d_width'($signed(d_l) >>> fb_shift);
    assign d_r_fb  = d_width'($signed(d_r) >>> fb_shift);

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            x_l <= '0;
            x_r <= '0;
            d_l <= '0;
            y_l <= '0;
            y_r <= '0;
            w_l <= '0;
            w_r <= '0;
        end else begin
            if (state == IDLE && tick) begin
                x_l <= l_data_rx;
                x_r <= r_data_rx;
            end
            if (state == RD_R) begin
                d_l <= primed ? ram_q : '0;
            end
            if (state == MIX) begin
                if (effect_en) begin
                    y_l <= add_sat(x_l, d_l_wet);
                    y_r <= add_sat(x_r, d_r_wet);
                    w_l <= add_sat(x_l, d_l_fb);
                    w_r <= add_sat(x_r, d_r_fb);
                end else begin
                    y_l <= x_l;
                    y_r <= x_r;
                    w_l <= x_l;
                    w_r <= x_r;
                end
            end
        end
    end

    // Outputs are loaded on the edge that enters DONE so that the new samples
    // and the sample_valid pulse are visible together during the DONE cycle.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            l_data_tx    <= '0;
            r_data_tx    <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= (state == WR_R);
            if (state == WR_R) begin
                l_data_tx <= y_l;
                r_data_tx <= y_r;
            end
        end
    end

    // Frame pointer and primed flag advance as DONE completes.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            ptr    <= '0;
            primed <= 1'b0;
        end else if (state == DONE) begin
            if (ptr == last_ptr) begin
                ptr    <= '0;
                primed <= 1'b1;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // A tick arriving mid-frame is dropped; the running frame is untouched.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (tick && state != IDLE) begin
            overrun <= 1'b1;
        end
    end

endmodule
